// File: rtl/add32_seq_arbiter.sv
// Round-robin shares one 8-bit adder between two clients for byte-serial 32-bit ADD/SUB.
// Latency 5..9 cycles (one extra pass per carried-in byte); req_ready only in IDLE, responses not backpressured.
module add32_seq_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_sum,
  output logic        resp_cout,
  output logic        resp_ovf,
  output logic        busy,
  output logic [8:0]  add_a,
  output logic [8:0]  add_b,
  input  logic [8:0]  add_sum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_INC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  idx_q, idx_d;
  logic        cin_q, cin_d;
  logic        c1_q, c1_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  resp_valid_q, resp_valid_d;

  logic        gnt;
  logic        gnt_op;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic [4:0]  bsel;
  logic        in_done;

  // Pointer client wins whenever it is requesting.
  assign gnt    = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign gnt_op = req_op[gnt];
  assign gnt_a  = gnt ? req_a1 : req_a0;
  assign gnt_b  = gnt ? req_b1 : req_b0;
  assign bsel   = {idx_q, 3'b000};

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    idx_d        = idx_q;
    cin_d        = cin_q;
    c1_d         = c1_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    resp_valid_d = 2'b00;
    req_ready    = 2'b00;
    add_a        = 9'd0;
    add_b        = 9'd0;

    case (state_q)
      S_IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          a_d       = gnt_a;
          b_d       = gnt_op ? ~gnt_b : gnt_b;
          owner_d   = gnt;
          idx_d     = 2'd0;
          cin_d     = gnt_op;
          ptr_d     = ~gnt;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        add_a = {1'b0, a_q[bsel +: 8]};
        add_b = {1'b0, b_q[bsel +: 8]};
        res_d[bsel +: 8] = add_sum[7:0];
        c1_d  = add_sum[8];
        // A pending carry-in costs an extra pass on the same byte.
        if (cin_q) begin
          state_d = S_INC;
        end else begin
          cin_d = add_sum[8];
          if (idx_q == 2'd3) begin
            state_d      = S_DONE;
            resp_valid_d = owner_q ? 2'b10 : 2'b01;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_INC: begin
        add_a = {1'b0, res_q[bsel +: 8]};
        add_b = 9'h001;
        res_d[bsel +: 8] = add_sum[7:0];
        cin_d = c1_q | add_sum[8];
        if (idx_q == 2'd3) begin
          state_d      = S_DONE;
          resp_valid_d = owner_q ? 2'b10 : 2'b01;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_ADD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      res_q        <= 32'd0;
      idx_q        <= 2'd0;
      cin_q        <= 1'b0;
      c1_q         <= 1'b0;
      owner_q      <= 1'b0;
      ptr_q        <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      cin_q        <= cin_d;
      c1_q         <= c1_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign in_done    = (state_q == S_DONE);
  assign resp_valid = resp_valid_q;
  assign resp_sum   = in_done ? res_q : 32'd0;
  assign resp_cout  = in_done & cin_q;
  assign resp_ovf   = in_done & (a_q[31] == b_q[31]) & (res_q[31] != a_q[31]);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_add32_seq_arbiter.sv
// Directed bench for add32_seq_arbiter with a behavioural adder and a result scoreboard.
module tb_add32_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_sum;
  logic        resp_cout;
  logic        resp_ovf;
  logic        busy;
  logic [8:0]  add_a, add_b, add_sum;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_viol = 0;

  add32_seq_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .resp_ovf(resp_ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Arithmetic reference; INC passes = bytes whose incoming carry is 1.
  function automatic exp_t model(input int client, input logic op,
                                 input logic [31:0] a, input logic [31:0] b, input int t0);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] full;
    logic [32:0] part;
    logic [31:0] mask;
    int          k;
    be   = op ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {32'd0, op};
    k    = op ? 1 : 0;
    for (int i = 1; i < 4; i++) begin
      mask = (32'd1 << (8 * i)) - 32'd1;
      part = {1'b0, a & mask} + {1'b0, be & mask} + {32'd0, op};
      if (part[8 * i]) k++;
    end
    e.vld  = (client == 1) ? 2'b10 : 2'b01;
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (a[31] == be[31]) && (full[31] != a[31]);
    e.t0   = t0;
    e.lat  = 5 + k;
    return e;
  endfunction

  task automatic wait_resp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy && req_ready != 2'b00) rdy_viol++;
      if (resp_valid != 2'b00) break;
    end
    if (resp_valid == 2'b00 || sb.size() == 0) begin
      check({tag, "_resp_timeout"}, 64'd1, 64'd0);
      sb.delete();
    end else begin
      e = sb.pop_front();
      check({tag, "_owner"}, resp_valid, e.vld);
      check({tag, "_sum"},   resp_sum,   e.sum);
      check({tag, "_cout"},  resp_cout,  e.cout);
      check({tag, "_ovf"},   resp_ovf,   e.ovf);
      check({tag, "_lat"},   cyc - e.t0, e.lat);
    end
  endtask

  // Waits for a grant; returns the granted client or -1 on timeout.
  task automatic wait_grant(output int client);
    int n;
    n = 0;
    client = -1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) break;
    end
    if (req_ready == 2'b01) client = 0;
    else if (req_ready == 2'b10) client = 1;
  endtask

  task automatic single_op(input string tag, input int client, input logic op,
                           input logic [31:0] a, input logic [31:0] b);
    int g;
    if (client == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_op[client]    = op;
    req_valid[client] = 1'b1;
    wait_grant(g);
    check({tag, "_grant"}, req_ready, (client == 1) ? 2'b10 : 2'b01);
    if (g < 0) begin
      req_valid = 2'b00;
    end else begin
      sb.push_back(model(client, op, a, b, cyc));
      @(posedge clk); #1;
      req_valid[client] = 1'b0;
      wait_resp(tag);
    end
  endtask

  initial begin
    int          g;
    int          seen;
    logic [31:0] ra, rb;
    logic        rop;

    rst = 1'b1; req_valid = 2'b00; req_op = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    #2;
    check("rst_busy",       busy,       1'b0);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_sum",   resp_sum,   32'd0);
    check("rst_cout_ovf",   {resp_cout, resp_ovf}, 2'b00);
    check("rst_add_ab",     {add_a, add_b}, 18'd0);
    check("rst_ready",      req_ready,  2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    single_op("basic_add", 0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
    @(posedge clk); #1;
    single_op("ripple",    1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    @(posedge clk); #1;
    single_op("sub",       0, 1'b1, 32'd5, 32'd7);
    @(posedge clk); #1;
    single_op("ovf",       0, 1'b1, 32'h8000_0000, 32'd1);
    @(posedge clk); #1;

    // Arbitration: both clients requesting continuously from reset.
    rst = 1'b1;
    req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
    req_op = 2'($urandom_range(0, 3));
    req_valid = 2'b11;
    #1;
    check("arb_rst_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      rdy_viol = 0;
      wait_grant(g);
      check("arb_grant", req_ready, (n % 2 == 1) ? 2'b10 : 2'b01);
      if (g < 0) break;
      ra  = (g == 1) ? req_a1 : req_a0;
      rb  = (g == 1) ? req_b1 : req_b0;
      rop = req_op[g];
      sb.push_back(model(g, rop, ra, rb, cyc));
      @(posedge clk); #1;
      if (g == 1) begin req_a1 = $urandom; req_b1 = $urandom; end
      else begin req_a0 = $urandom; req_b0 = $urandom; end
      req_op[g] = 1'($urandom_range(0, 1));
      wait_resp("arb");
      check("arb_ready_while_busy", rdy_viol, 0);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Reset in cycle T0+3 aborts the op with no response.
    req_a0 = 32'h0000_00FF; req_b0 = 32'h0000_0001; req_op[0] = 1'b0;
    req_valid[0] = 1'b1;
    wait_grant(g);
    check("midrst_grant", req_ready, 2'b01);
    sb.push_back(model(0, 1'b0, req_a0, req_b0, cyc));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_busy",       busy,       1'b0);
    check("midrst_add_ab",     {add_a, add_b}, 18'd0);
    check("midrst_resp_valid", resp_valid, 2'b00);
    check("midrst_resp_sum",   resp_sum,   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen++;
    end
    check("midrst_no_resp", seen, 0);
    @(posedge clk); #1;
    single_op("after_rst", 1, 1'b0, 32'h1234_5678, 32'h0FED_CBA9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add32_seq_arbiter.md
# add32_seq_arbiter

Shares the 8-bit adder datapath (8+8 → 9-bit sum, no carry-in) between two requesters to perform 32-bit ADD/SUB. It arbitrates round-robin, then sequences the operation byte-serially through the adder. When a byte's carry-in is 1, it spends one extra pass adding 1 to that byte. It sits between the ALU/address-generation clients and the single adder instance, and owns the adder's A/B inputs.

## Interface
- No parameters; widths are fixed (32-bit operands, 8-bit adder slice, 2 clients).
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  2  per-client request; must hold with operands stable until req_ready
- req_op  in  2  per-client op: 0 = ADD, 1 = SUB (a − b)
- req_a0, req_b0  in  32 each  client 0 operands
- req_a1, req_b1  in  32 each  client 1 operands
- req_ready  out  2  grant/accept strobe, one-hot or zero, combinational, asserted only in IDLE
- resp_valid  out  2  one-cycle result strobe to the owning client (registered)
- resp_sum  out  32  result, valid while resp_valid≠0
- resp_cout  out  1  carry out of bit 31 (for SUB, 1 = no borrow)
- resp_ovf  out  1  signed overflow
- busy  out  1  high in every state except IDLE
- add_a, add_b  out  9 each  adder operands; bit 8 is always 0
- add_sum  in  9  combinational adder result; bit 8 is the carry out of bit 7

## Operation
- States: IDLE, ADD, INC, DONE.
- **IDLE**
  - If any req_valid, grant one client: pointer client if it is valid, else the other.
  - Assert req_ready for the granted client only.
  - Latch a, b_eff (b for ADD, ~b for SUB), op, owner.
  - Set idx = 0 and cin = op (SUB injects +1 at byte 0).
  - Toggle the pointer to the non-granted client. Go to ADD.
- **ADD**
  - Drive add_a = {0, a[idx]} and add_b = {0, b_eff[idx]}.
  - Write add_sum[7:0] into res[idx] and save c1 = add_sum[8].
  - If cin = 1, go to INC.
  - Else set cin = c1. If idx = 3, go to DONE; otherwise increment idx and stay in ADD.
- **INC**
  - Drive add_a = {0, res[idx]} and add_b = 9'h001.
  - Write add_sum[7:0] into res[idx] and set cin = c1 | add_sum[8]. c1 and the INC carry are never both 1.
  - If idx = 3, go to DONE; otherwise increment idx and go to ADD.
- **DONE**
  - Assert resp_valid[owner] for exactly one cycle.
  - resp_sum = res, resp_cout = cin.
  - resp_ovf = (a[31] == b_eff[31]) & (res[31] != a[31]).
  - Go to IDLE.
- add_a and add_b are 0 in IDLE and DONE.
- No response backpressure: a client must accept resp_valid when it arrives.
- Simultaneous valids: the pointer client wins. A losing or late request waits, with req_ready low, until the next IDLE.
- A request that deasserts before req_ready is dropped silently (protocol violation, no error).

## Timing
- Reset (async, immediate):
  - state = IDLE, pointer = client 0.
  - res, a, b_eff, idx, cin, c1, owner all 0.
  - req_ready = 0, resp_valid = 0, resp_sum = 0, resp_cout = 0, resp_ovf = 0, busy = 0, add_a = 0, add_b = 0.
- Accept at cycle T0 (IDLE). ADD byte 0 at T1. DONE at T1+4+k, where k = number of INC passes (0..4).
- resp_valid is high in cycle T0+5+k, so latency is 5..9 cycles.
- Next accept is possible in the cycle after DONE. Maximum throughput is one op per 6 cycles.
- The adder path is purely combinational within one cycle: add_a/add_b in, add_sum sampled at the same edge.
- Reset mid-operation aborts the op and issues no resp_valid. The pointer returns to client 0.

## Test plan
- **Basic ADD.** Client 0 ADD 0x0000_00FF + 0x0000_0001.
  - Expect resp_sum = 0x0000_0100, cout = 0, ovf = 0.
  - Expect one INC pass (byte 1), resp_valid[0] at T0+6.
- **Carry ripple.** Client 1 ADD 0xFFFF_FFFF + 0x0000_0001.
  - Expect sum = 0, cout = 1, ovf = 0.
  - Expect INC on bytes 1–3, resp_valid[1] at T0+8.
- **SUB.** Client 0 SUB 5 − 7.
  - Expect sum = 0xFFFF_FFFE, cout = 0.
- **Signed overflow.** Client 0 SUB 0x8000_0000 − 1.
  - Expect sum = 0x7FFF_FFFF, cout = 1, ovf = 1.
- **Arbitration.** Both clients valid from reset with continuous requests.
  - Grants must alternate 0, 1, 0, 1.
  - Each request waits with req_ready low while busy.
  - The response goes only to the owner.
- **Reset mid-op.** Assert rst in cycle T0+3 of an op.
  - Outputs must go to 0 immediately and no resp_valid may appear.
  - After release, client 1 alone gets granted and completes normally.
